// File: rtl/mem_wait.sv
// mem_wait: single-port word memory with a fixed number of wait states per
// access, fronted by a three-state handshake FSM (IDLE -> WAIT -> ACK).
//
// Parameters:
//   WIDTH  data word width in bits (multiple of 8)
//   DEPTH  number of words (power of 2, at least 2)
//   WAIT   wait-state cycles per access (0 allowed)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   req    access request, accepted in IDLE or ACK
//   we     1 = write, 0 = read
//   adr    byte address (word index = adr >> log2(WIDTH/8))
//   wdata  write data
//   be     byte enables, bit i covers wdata[8i+7:8i]
//   rdata  registered read data (held across writes)
//   ack    one-cycle completion strobe (state == ACK)
//   busy   access in flight (WAIT or ACK)
//   err    access error, valid while ack is high
//   state  FSM state for test: IDLE=0, WAIT=1, ACK=2
//
// Optional feature: define MEM_WAIT_ERR_EN to flag misaligned or
// out-of-range addresses with err=1 (no write, rdata=0). Without it, err
// is 0, the low address bits are ignored and the index wraps modulo DEPTH.

module mem_wait #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [31:0]        adr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] be,
    output logic [WIDTH-1:0]   rdata,
    output logic               ack,
    output logic               busy,
    output logic               err,
    output logic [1:0]         state
);
    localparam int NB       = WIDTH / 8;
    localparam int OFF      = $clog2(NB);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam int CNT_LOAD = (WAIT > 0) ? WAIT - 1 : 0;
    localparam bit NO_WAIT  = (WAIT == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           st;
    logic [CW-1:0]    cnt;
    logic             cap_we;
    logic [31:0]      cap_adr;
    logic [WIDTH-1:0] cap_wdata;
    logic [NB-1:0]    cap_be;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             enter_ack;
    logic             acc_we;
    logic [31:0]      acc_adr;
    logic [WIDTH-1:0] acc_wdata;
    logic [NB-1:0]    acc_be;
    logic [31:0]      word;
    logic [AW-1:0]    idx;
    logic             bad;
    logic             commit;
    logic             unused_bits;

    assign accept    = req && (st == S_IDLE || st == S_ACK);
    assign enter_ack = (st == S_WAIT && cnt == '0) || (accept && NO_WAIT);

    // With no wait states the access completes on its acceptance edge, so
    // it works straight from the ports rather than from the capture regs.
    assign acc_we    = NO_WAIT ? we    : cap_we;
    assign acc_adr   = NO_WAIT ? adr   : cap_adr;
    assign acc_wdata = NO_WAIT ? wdata : cap_wdata;
    assign acc_be    = NO_WAIT ? be    : cap_be;

    assign word = acc_adr >> OFF;
    assign idx  = word[AW-1:0];

`ifdef MEM_WAIT_ERR_EN
    assign bad = ((acc_adr & 32'(NB - 1)) != 32'd0) || (word >= 32'(DEPTH));
`else
    assign bad = 1'b0;
`endif

    // Address bits above the index (and below it) matter only for error
    // detection; fold them here so the default build carries no dangling bits.
    assign unused_bits = ^{acc_adr, word};

    // Reset gates the commit so an aborted access never reaches the array.
    assign commit = reset && enter_ack && acc_we && !bad;

    assign state = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_adr   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rdata     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= we;
                cap_adr   <= adr;
                cap_wdata <= wdata;
                cap_be    <= be;
                busy      <= 1'b1;
                err       <= 1'b0;
                if (NO_WAIT) begin
                    st  <= S_ACK;
                    ack <= 1'b1;
                end else begin
                    st  <= S_WAIT;
                    cnt <= CW'(CNT_LOAD);
                    ack <= 1'b0;
                end
            end else if (st == S_WAIT) begin
                if (cnt == '0) begin
                    st  <= S_ACK;
                    ack <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else begin
                // ACK without a new request, IDLE, or the unused encoding.
                st   <= S_IDLE;
                ack  <= 1'b0;
                busy <= 1'b0;
                err  <= 1'b0;
            end

            // Completion: the array is read before this edge's write, and
            // any earlier write has already landed, so no bypass is needed.
            if (enter_ack) begin
                err <= bad;
                if (bad) begin
                    rdata <= '0;
                end else if (!acc_we) begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // Array has no reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/mem_wait.md
MEM_WAIT -- requirements
Module: mem_wait

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 64, giving the number of words; it must be a power of 2.
REQ-003 The block SHALL have parameter WAIT, default 2, giving the number of wait-state cycles per access; 0 and above are legal.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, 1 bit: access request.
REQ-007 The block SHALL have port we, input, 1 bit: 1 for write, 0 for read.
REQ-008 The block SHALL have port adr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-010 The block SHALL have port be, input, WIDTH/8 bits: byte enables; bit i covers wdata[8i+7:8i].
REQ-011 The block SHALL have port rdata, output, WIDTH bits: registered read data.
REQ-012 The block SHALL have port ack, output, 1 bit: one-cycle completion strobe per access.
REQ-013 The block SHALL have port busy, output, 1 bit: high while an access is in flight (states WAIT and ACK).
REQ-014 The block SHALL have port err, output, 1 bit: access error flag, valid while ack is high.
REQ-015 The block SHALL have port state, output, 2 bits: FSM state for test (IDLE=0, WAIT=1, ACK=2).

Function
REQ-016 The block SHALL hold a DEPTH x WIDTH array, with word index = adr >> log2(WIDTH/8), taken modulo DEPTH.
REQ-017 The FSM SHALL have exactly three states (IDLE, WAIT, ACK) and no other reachable encoding.
REQ-018 The block SHALL accept a request at a rising edge when req=1 and the state is IDLE or ACK, capturing we, adr, wdata and be.
REQ-019 On acceptance, the FSM SHALL go to WAIT and load the counter with WAIT-1 when WAIT>0, and go directly to ACK when WAIT=0.
REQ-020 In WAIT, the FSM SHALL go to ACK when the counter equals 0 and otherwise decrement the counter.
REQ-021 On the edge entering ACK, the block SHALL write the enabled bytes of a write and register the full addressed word into rdata for a read.
REQ-022 ack SHALL equal (state==ACK) and be high exactly WAIT+1 cycles after the acceptance edge.
REQ-023 From ACK, the FSM SHALL go to IDLE when req=0, or accept the new request per REQ-018 when req=1.
REQ-024 Back-to-back requests SHALL complete one every WAIT+1 cycles, so with WAIT=0 ack stays continuously high.
REQ-025 The block SHALL ignore req, and SHALL NOT modify captured values, while in WAIT.
REQ-026 For a write, rdata SHALL hold its previous value; be=0 SHALL complete with ack and leave memory unchanged.
REQ-027 A read in ACK SHALL return data including any write completed on an earlier edge, with no stale bypass hazard.

Reset
REQ-028 Asserting reset SHALL immediately set state=IDLE, counter=0, rdata=0, ack=0, busy=0 and err=0.
REQ-029 A reset during WAIT or ACK SHALL abort the access: no write is committed if reset arrives before the ACK-entry edge, and no ack is issued.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 After reset deassertion, the first accepted request SHALL behave as in REQ-018 to REQ-022.

Configuration
REQ-032 With macro MEM_WAIT_ERR_EN defined, an access whose adr low log2(WIDTH/8) bits are nonzero, or whose word index is at least DEPTH before the modulo, SHALL complete normally in timing with err=1, no array write and rdata=0.
REQ-033 With MEM_WAIT_ERR_EN undefined, err SHALL be tied to 0, low address bits SHALL be ignored, and the index SHALL wrap modulo DEPTH.

Verification
REQ-034 Scenario: WIDTH=32, DEPTH=64, WAIT=2; write 0xDEADBEEF to adr 0x10 with be=4'b1111, then read 0x10 -> each ack arrives 3 cycles after acceptance, and rdata=0xDEADBEEF.
REQ-035 Scenario: write 0x11223344 to 0x20, then write 0x00550000 to 0x20 with be=4'b0100, then read 0x20 -> rdata=0x11553344.
REQ-036 Scenario: WAIT=0, req held high for 4 reads of 0x0, 0x4, 0x8, 0xC -> ack is high for 4 consecutive cycles with the correct data each cycle.
REQ-037 Scenario: WAIT=2, req held high for 3 accesses -> ack is high on cycles 3, 6 and 9 after the first acceptance, and busy stays high throughout.
REQ-038 Scenario (MEM_WAIT_ERR_EN defined): read of 0x102 and write of 0x100 -> each completes with err=1 and rdata=0, and word 0 is unchanged. Same scenario (macro undefined) -> the write to 0x100 lands in word 0, and err=0.
REQ-039 Scenario: word 0x30 holds 0x12345678; accept a write of 0xFFFFFFFF to 0x30, then assert reset one cycle later in WAIT -> ack never rises, state=0, and a subsequent read of 0x30 returns 0x12345678.
